// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : RV32I integer ALU. Eleven operations on two XLEN-bit operands,
//            selected by a 4-bit opcode. The result and zero flag are purely
//            combinational. A one-stage registered copy of result, zero and
//            the valid strobe is provided for pipelined consumers.
// Ports    :
//   clk        in   1     rising-edge clock (registered outputs only)
//   rst_n      in   1     asynchronous active-low reset
//   src_a      in   XLEN  operand A
//   src_b      in   XLEN  operand B (shift amount in low bits)
//   alu_op     in   4     operation select
//   in_valid   in   1     qualifies operands for capture into result_q/zero_q
//   result     out  XLEN  combinational result
//   zero       out  1     combinational, high when result == 0
//   result_q   out  XLEN  registered result
//   zero_q     out  1     registered zero flag
//   out_valid  out  1     registered in_valid
// Revision : 1.0 - initial release
// ============================================================================
module alu_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [3:0]      alu_op,
  input  logic            in_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q,
  output logic            out_valid
);

  localparam int          SHW     = $clog2(XLEN);

  localparam logic [3:0]  OP_ADD   = 4'b0000;
  localparam logic [3:0]  OP_SUB   = 4'b0001;
  localparam logic [3:0]  OP_AND   = 4'b0010;
  localparam logic [3:0]  OP_OR    = 4'b0011;
  localparam logic [3:0]  OP_XOR   = 4'b0100;
  localparam logic [3:0]  OP_SLL   = 4'b0101;
  localparam logic [3:0]  OP_SRL   = 4'b0110;
  localparam logic [3:0]  OP_SLT   = 4'b0111;
  localparam logic [3:0]  OP_SLTU  = 4'b1000;
  localparam logic [3:0]  OP_SRA   = 4'b1001;
  localparam logic [3:0]  OP_PASSB = 4'b1010;

  // Only the low bits of B form the shift amount; upper bits are ignored,
  // so a shift by XLEN wraps to a shift by 0.
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_result;
  logic            w_zero;

  logic [XLEN-1:0] r_result_q;
  logic            r_zero_q;
  logic            r_out_valid;

  assign w_shamt = src_b[SHW-1:0];

  always_comb begin
    w_result = '0;
    unique case (alu_op)
      OP_ADD:   w_result = src_a + src_b;
      OP_SUB:   w_result = src_a - src_b;
      OP_AND:   w_result = src_a & src_b;
      OP_OR:    w_result = src_a | src_b;
      OP_XOR:   w_result = src_a ^ src_b;
      OP_SLL:   w_result = src_a << w_shamt;
      OP_SRL:   w_result = src_a >> w_shamt;
      OP_SLT:   w_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU:  w_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_SRA:   w_result = $unsigned($signed(src_a) >>> w_shamt);
      OP_PASSB: w_result = src_b;
      default:  w_result = '0;
    endcase
  end

  assign w_zero = ~|w_result;
  assign result = w_result;
  assign zero   = w_zero;

  // Registered copy. Reset value of zero_q is 1 so it stays consistent with
  // the cleared result_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_q  <= '0;
      r_zero_q    <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result_q <= w_result;
        r_zero_q   <= w_zero;
      end
    end
  end

  assign result_q  = r_result_q;
  assign zero_q    = r_zero_q;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_core
// Purpose  : Self-checking directed testbench for alu_core. Each task drives
//            one feature's vectors and compares against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  alu_op;
  logic        in_valid;
  logic [31:0] result;
  logic        zero;
  logic [31:0] result_q;
  logic        zero_q;
  logic        out_valid;

  int tests;
  int fails;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_z;
  } vec_t;

  alu_core #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_a    (src_a),
    .src_b    (src_b),
    .alu_op   (alu_op),
    .in_valid (in_valid),
    .result   (result),
    .zero     (zero),
    .result_q (result_q),
    .zero_q   (zero_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    src_a  = a;
    src_b  = b;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (result_q !== 32'h0 || zero_q !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: got result_q=%h zero_q=%b out_valid=%b, want 00000000 1 0",
               result_q, zero_q, out_valid);
    end
  endtask

  task automatic test_comb(input string name, input vec_t v[]);
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      #1;
      tests++;
      if (result !== v[i].exp || zero !== v[i].exp_z) begin
        fails++;
        $display("FAIL %s[%0d] op=%b a=%h b=%h: got result=%h zero=%b, want %h %b",
                 name, i, v[i].op, v[i].a, v[i].b, result, zero, v[i].exp, v[i].exp_z);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[] = '{
      '{4'b0000, 32'h1,        32'h1, 32'h2,        1'b0},
      '{4'b0001, 32'h2,        32'h1, 32'h1,        1'b0},
      '{4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0,        1'b1},
      '{4'b0001, 32'h0,        32'h1, 32'hFFFFFFFF, 1'b0},
      '{4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0}
    };
    test_comb("arith", v);
  endtask

  task automatic test_logic();
    vec_t v[] = '{
      '{4'b0010, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1},
      '{4'b0011, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
      '{4'b0100, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
      '{4'b0010, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'h00F0A5A5, 1'b0},
      '{4'b0100, 32'h12345678, 32'h12345678, 32'h0,        1'b1}
    };
    test_comb("logic", v);
  endtask

  task automatic test_shift();
    vec_t v[] = '{
      '{4'b0101, 32'h1,        32'h1,  32'h2,        1'b0},
      '{4'b0110, 32'h2,        32'h1,  32'h1,        1'b0},
      '{4'b1001, 32'h80000000, 32'h4,  32'hF8000000, 1'b0},
      '{4'b0110, 32'h80000000, 32'h4,  32'h08000000, 1'b0},
      '{4'b0101, 32'h1,        32'd33, 32'h2,        1'b0},
      '{4'b0101, 32'hABCD1234, 32'h0,  32'hABCD1234, 1'b0},
      '{4'b1001, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0},
      '{4'b0110, 32'h80000000, 32'd31, 32'h1,        1'b0},
      '{4'b0101, 32'h1,        32'd31, 32'h80000000, 1'b0},
      '{4'b0110, 32'h12345678, 32'd32, 32'h12345678, 1'b0},
      '{4'b1001, 32'h40000000, 32'd4,  32'h04000000, 1'b0}
    };
    test_comb("shift", v);
  endtask

  task automatic test_compare();
    vec_t v[] = '{
      '{4'b0111, 32'h1,        32'h2,        32'h1, 1'b0},
      '{4'b1000, 32'h1,        32'h2,        32'h1, 1'b0},
      '{4'b0111, 32'h80000000, 32'h0,        32'h1, 1'b0},
      '{4'b1000, 32'h80000000, 32'h0,        32'h0, 1'b1},
      '{4'b0111, 32'h5,        32'h5,        32'h0, 1'b1},
      '{4'b1000, 32'h5,        32'h5,        32'h0, 1'b1},
      '{4'b0111, 32'h0,        32'hFFFFFFFF, 32'h0, 1'b1},
      '{4'b1000, 32'h0,        32'hFFFFFFFF, 32'h1, 1'b0}
    };
    test_comb("compare", v);
  endtask

  task automatic test_misc();
    vec_t v[] = '{
      '{4'b1010, 32'h0,        32'h12345000, 32'h12345000, 1'b0},
      '{4'b1011, 32'hFFFFFFFF, 32'h12345678, 32'h0,        1'b1},
      '{4'b1100, 32'h1,        32'h1,        32'h0,        1'b1},
      '{4'b1101, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,        1'b1},
      '{4'b1110, 32'h80000000, 32'h7FFFFFFF, 32'h0,        1'b1},
      '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1}
    };
    test_comb("misc", v);
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    drive(4'b0000, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    tests++;
    if (result_q !== 32'd7 || zero_q !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reg_capture: got result_q=%h zero_q=%b out_valid=%b, want 00000007 0 1",
               result_q, zero_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drive(4'b0001, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    tests++;
    if (result_q !== 32'd7 || zero_q !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reg_hold: got result_q=%h zero_q=%b out_valid=%b, want 00000007 0 0",
               result_q, zero_q, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[] = '{
      '{4'b0001, 32'd9,        32'd9,  32'h0,        1'b1},
      '{4'b0101, 32'h1,        32'd4,  32'h10,       1'b0},
      '{4'b1010, 32'h0,        32'hAB, 32'hAB,       1'b0},
      '{4'b1001, 32'h80000000, 32'd8,  32'hFF800000, 1'b0}
    };
    foreach (v[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      drive(v[i].op, v[i].a, v[i].b);
      @(posedge clk);
      #1;
      tests++;
      if (result_q !== v[i].exp || zero_q !== v[i].exp_z || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b[%0d]: got result_q=%h zero_q=%b out_valid=%b, want %h %b 1",
                 i, result_q, zero_q, out_valid, v[i].exp, v[i].exp_z);
      end
    end
  endtask

  task automatic test_async_reset_mid();
    // Capture a value, then assert reset away from any edge.
    @(negedge clk);
    in_valid = 1'b1;
    drive(4'b0011, 32'h00F0, 32'h0F00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (result_q !== 32'h0 || zero_q !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got result_q=%h zero_q=%b out_valid=%b, want 00000000 1 0",
               result_q, zero_q, out_valid);
    end
    // Pending capture with reset held across an edge is discarded.
    @(posedge clk);
    #1;
    tests++;
    if (result_q !== 32'h0 || zero_q !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got result_q=%h zero_q=%b out_valid=%b, want 00000000 1 0",
               result_q, zero_q, out_valid);
    end
    // First edge after release captures.
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 32'd20, 32'd22);
    @(posedge clk);
    #1;
    tests++;
    if (result_q !== 32'd42 || zero_q !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: got result_q=%h zero_q=%b out_valid=%b, want 0000002a 0 1",
               result_q, zero_q, out_valid);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive(4'b0000, 32'h0, 32'h0);

    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_compare();
    test_misc();
    test_registered();
    test_back_to_back();
    test_async_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
